// File: rtl/cw_clock_pkg.sv
// Shared constants for the clock's 3:1 display/data-path mux and the mode FSM.
// The FSM state encoding is the one-hot mux select itself.
package cw_clock_pkg;

   localparam logic [2:0] SEL_A = 3'b100;
   localparam logic [2:0] SEL_B = 3'b010;
   localparam logic [2:0] SEL_C = 3'b001;

   typedef enum logic [2:0] {
      ST_DISP  = SEL_A,
      ST_SET_B = SEL_B,
      ST_SET_C = SEL_C
   } cw_state_e;

endpackage

// File: rtl/cw_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-count debouncer, registered rise detect.
// press_o goes high 2+DEBOUNCE_CYCLES edges after the raw rise is first sampled.
module cw_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d, deb_prev_q;
   logic          press_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count consecutive clocks the synchronized level disagrees with the debounced one.
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         cnt_q      <= '0;
         press_q    <= 1'b0;
      end else begin
         sync1_q    <= btn_i;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         cnt_q      <= cnt_d;
         press_q    <= deb_q & ~deb_prev_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/cw_mode_sel.sv
// Front-panel mode controller: debounced Mode/Adjust buttons drive a one-hot mux select,
// adjust pulses, a mode-change pulse and a blink enable. All outputs registered.
module cw_mode_sel
   import cw_clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TIMEOUT_TICKS   = 10
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tick_1hz_i,
   input  logic       btn_mode_i,
   input  logic       btn_adj_i,
   output logic [2:0] sel_o,
   output logic       adj_pulse_o,
   output logic       mode_change_o,
   output logic       blink_o
);

   localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

   logic          mode_press, adj_press;
   cw_state_e     state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          blink_q, blink_d;
   logic          adj_q, adj_d;
   logic          mc_q, mc_d;

   cw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (btn_mode_i),
      .press_o (mode_press)
   );

   cw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_adj (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (btn_adj_i),
      .press_o (adj_press)
   );

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      blink_d = blink_q;
      adj_d   = 1'b0;
      case (state_q)
         ST_DISP: begin
            tcnt_d  = '0;
            blink_d = 1'b0;
            if (mode_press) state_d = ST_SET_B;
         end
         ST_SET_B, ST_SET_C: begin
            if (tick_1hz_i) blink_d = ~blink_q;
            // Priority: mode press, then adjust press, then timeout tick.
            if (mode_press) begin
               state_d = (state_q == ST_SET_B) ? ST_SET_C : ST_DISP;
            end else if (adj_press) begin
               adj_d  = 1'b1;
               tcnt_d = '0;
            end else if (tick_1hz_i) begin
               if (tcnt_q == TW'(TIMEOUT_TICKS - 1)) state_d = ST_DISP;
               else                                  tcnt_d  = tcnt_q + 1'b1;
            end
         end
         default: state_d = ST_DISP;
      endcase
      if (state_d != state_q) begin
         tcnt_d  = '0;
         blink_d = (state_d != ST_DISP);
      end
      mc_d = (state_d != state_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_DISP;
         tcnt_q  <= '0;
         blink_q <= 1'b0;
         adj_q   <= 1'b0;
         mc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         blink_q <= blink_d;
         adj_q   <= adj_d;
         mc_q    <= mc_d;
      end
   end

   assign sel_o         = state_q;
   assign adj_pulse_o   = adj_q;
   assign mode_change_o = mc_q;
   assign blink_o       = blink_q;

endmodule
